// File: rtl/centroid_update_if.sv
// Bundle of the control handshake and data buses for centroid_update.
// The master side (the requester) drives start, current centroids, sums and counts.
// The slave side (centroid_update) returns updated centroids, status and flags.
interface centroid_update_if #(
    parameter int SUM_W = 12,
    parameter int CNT_W = 8
);
    logic             start;
    logic             busy;
    logic             done;
    logic             converged;
    logic [2:0]       empty_mask;
    logic [15:0]      cen_in0, cen_in1, cen_in2;
    logic [15:0]      cen_out0, cen_out1, cen_out2;
    logic [SUM_W-1:0] sum_x0, sum_x1, sum_x2;
    logic [SUM_W-1:0] sum_y0, sum_y1, sum_y2;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2;

    modport master (
        output start, cen_in0, cen_in1, cen_in2,
               sum_x0, sum_x1, sum_x2, sum_y0, sum_y1, sum_y2,
               cnt0, cnt1, cnt2,
        input  busy, done, converged, empty_mask,
               cen_out0, cen_out1, cen_out2
    );

    modport slave (
        input  start, cen_in0, cen_in1, cen_in2,
               sum_x0, sum_x1, sum_x2, sum_y0, sum_y1, sum_y2,
               cnt0, cnt1, cnt2,
        output busy, done, converged, empty_mask,
               cen_out0, cen_out1, cen_out2
    );
endinterface

// File: rtl/centroid_update.sv
// K-means centroid update for three 2-D clusters: new coordinate = sum / count,
// computed by one shared restoring divider, six divisions in sequence x0,y0,..,y2.
// Build option: define KMEAN_ROUND_EN for round-to-nearest division
// (sum + floor(cnt/2)) / cnt; otherwise the division truncates.
module centroid_update #(
    parameter int SUM_W = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    centroid_update_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int         BC_W    = $clog2(SUM_W + 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       idx_q;
    logic [BC_W-1:0]  bit_q;
    logic [CNT_W-1:0] rem_q;
    logic [SUM_W-1:0] dvd_q;
    logic [SUM_W:0]   quo_q;
    logic [47:0]      res_q, res_d;
    logic [15:0]      cin_q [3];
    logic [SUM_W-1:0] sx_q [3];
    logic [SUM_W-1:0] sy_q [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [15:0]      cen_out_q [3];
    logic             conv_q;
    logic [2:0]       empty_q;

    logic [CNT_W-1:0] cur_cnt, ncnt;
    logic [15:0]      cur_cin;
    logic [7:0]       cur_keep, st_val;
    logic [2:0]       nidx;
    logic [SUM_W-1:0] nsum;
    logic [SUM_W:0]   ndvd;
    logic [CNT_W:0]   init_r, step_r;
    logic             init_q, step_q;
    logic [CNT_W-1:0] init_rem, step_rem;
    logic [15:0]      new0, new1, new2;

    // Clamp a quotient to the 8-bit coordinate range.
    function automatic logic [7:0] sat8(input logic [SUM_W:0] q);
        if (q > (SUM_W + 1)'(255)) return 8'hFF;
        return q[7:0];
    endfunction

    // Operands of the division in progress; cnt=0 keeps the latched coordinate.
    always_comb begin
        cur_cnt = cnt_q[0];
        cur_cin = cin_q[0];
        case (idx_q[2:1])
            2'd1:    begin cur_cnt = cnt_q[1]; cur_cin = cin_q[1]; end
            2'd2:    begin cur_cnt = cnt_q[2]; cur_cin = cin_q[2]; end
            default: ;
        endcase
        cur_keep = idx_q[0] ? cur_cin[7:0] : cur_cin[15:8];
        st_val   = (cur_cnt == '0) ? cur_keep : sat8(quo_q);
        step_r   = {rem_q, dvd_q[SUM_W-1]};
        step_q   = (step_r >= {1'b0, cur_cnt});
        step_rem = step_q ? CNT_W'(step_r - {1'b0, cur_cnt}) : CNT_W'(step_r);
    end

    // Operands of the next division; the dividend MSB is resolved at setup so
    // the remaining SUM_W bits fit exactly SUM_W cycles even when rounding.
    always_comb begin
        nidx = idx_q + 3'd1;
        nsum = sx_q[0];
        ncnt = cnt_q[0];
        if (state_q == S_LOAD) begin
            nsum = bus.sum_x0;
            ncnt = bus.cnt0;
        end else begin
            case (nidx)
                3'd1:    begin nsum = sy_q[0]; ncnt = cnt_q[0]; end
                3'd2:    begin nsum = sx_q[1]; ncnt = cnt_q[1]; end
                3'd3:    begin nsum = sy_q[1]; ncnt = cnt_q[1]; end
                3'd4:    begin nsum = sx_q[2]; ncnt = cnt_q[2]; end
                3'd5:    begin nsum = sy_q[2]; ncnt = cnt_q[2]; end
                default: ;
            endcase
        end
`ifdef KMEAN_ROUND_EN
        ndvd = {1'b0, nsum} + (SUM_W + 1)'(ncnt >> 1);
`else
        ndvd = {1'b0, nsum};
`endif
        init_r   = {{CNT_W{1'b0}}, ndvd[SUM_W]};
        init_q   = (init_r >= {1'b0, ncnt});
        init_rem = init_q ? CNT_W'(init_r - {1'b0, ncnt}) : CNT_W'(init_r);
    end

    // Result buffer with the current quotient merged in, and the packed centroids.
    always_comb begin
        res_d = res_q;
        res_d[{idx_q, 3'b000} +: 8] = st_val;
        new0 = {res_d[7:0],   res_d[15:8]};
        new1 = {res_d[23:16], res_d[31:24]};
        new2 = {res_d[39:32], res_d[47:40]};
    end

    // Sequencer: IDLE -> LOAD -> (DIV x SUM_W, STORE) x 6 -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_DIV;
            S_DIV:   if (bit_q == '0) state_d = S_STORE;
            S_STORE: state_d = (idx_q == 3'd5) ? S_DONE : S_DIV;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand latches, divider datapath and published results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            conv_q  <= 1'b0;
            empty_q <= '0;
            for (int k = 0; k < 3; k++) begin
                cin_q[k]     <= '0;
                sx_q[k]      <= '0;
                sy_q[k]      <= '0;
                cnt_q[k]     <= '0;
                cen_out_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_LOAD: begin
                    cin_q[0] <= bus.cen_in0; cin_q[1] <= bus.cen_in1; cin_q[2] <= bus.cen_in2;
                    sx_q[0]  <= bus.sum_x0;  sx_q[1]  <= bus.sum_x1;  sx_q[2]  <= bus.sum_x2;
                    sy_q[0]  <= bus.sum_y0;  sy_q[1]  <= bus.sum_y1;  sy_q[2]  <= bus.sum_y2;
                    cnt_q[0] <= bus.cnt0;    cnt_q[1] <= bus.cnt1;    cnt_q[2] <= bus.cnt2;
                    idx_q    <= '0;
                    dvd_q    <= ndvd[SUM_W-1:0];
                    rem_q    <= init_rem;
                    quo_q    <= {{SUM_W{1'b0}}, init_q};
                    bit_q    <= BC_W'(SUM_W - 1);
                end
                S_DIV: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[SUM_W-1:0], step_q};
                    dvd_q <= {dvd_q[SUM_W-2:0], 1'b0};
                    bit_q <= bit_q - 1'b1;
                end
                S_STORE: begin
                    res_q <= res_d;
                    if (idx_q == 3'd5) begin
                        cen_out_q[0] <= new0;
                        cen_out_q[1] <= new1;
                        cen_out_q[2] <= new2;
                        conv_q  <= (new0 == cin_q[0]) && (new1 == cin_q[1]) && (new2 == cin_q[2]);
                        empty_q <= {cnt_q[2] == '0, cnt_q[1] == '0, cnt_q[0] == '0};
                    end else begin
                        idx_q <= nidx;
                        dvd_q <= ndvd[SUM_W-1:0];
                        rem_q <= init_rem;
                        quo_q <= {{SUM_W{1'b0}}, init_q};
                        bit_q <= BC_W'(SUM_W - 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.converged  = conv_q;
    assign bus.empty_mask = empty_q;
    assign bus.cen_out0   = cen_out_q[0];
    assign bus.cen_out1   = cen_out_q[1];
    assign bus.cen_out2   = cen_out_q[2];
endmodule

// File: doc/centroid_update.md
CENTROID_UPDATE -- requirements
Module: centroid_update

Interface
REQ-001 Parameter SUM_W, default 12: width of each per-cluster coordinate sum.
REQ-002 Parameter CNT_W, default 8: width of each per-cluster point count.
REQ-003 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-006 start  input  1  request one centroid update; sampled only in IDLE.
REQ-007 cen_in0/1/2  input  16 each  current centroids; [15:8]=x, [7:0]=y.
REQ-008 sum_x0/1/2, sum_y0/1/2  input  SUM_W each  per-cluster coordinate sums.
REQ-009 cnt0/1/2  input  CNT_W each  per-cluster point counts.
REQ-010 cen_out0/1/2  output  16 each  updated centroids, same packing as cen_in.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when cen_out* and flags are valid.
REQ-013 converged  output  1  all three new centroids equal the latched cen_in values.
REQ-014 empty_mask  output  3  bit k set when cnt k was zero in the last update.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, DIV, STORE, DONE.
REQ-016 IDLE->LOAD when start=1; start is ignored in all other states.
REQ-017 LOAD (1 cycle) SHALL latch all cen_in, sum and cnt inputs; later input changes do not affect the update in progress.
REQ-018 Six divisions SHALL run in order x0,y0,x1,y1,x2,y2, each using one shared restoring shift-subtract divider.
REQ-019 Each division SHALL take exactly SUM_W cycles in DIV, followed by 1 cycle in STORE; STORE goes to DIV for the next index, or to DONE after index 5.
REQ-020 DONE (1 cycle) SHALL update cen_out0..2, converged and empty_mask simultaneously, assert done, then return to IDLE.
REQ-021 Latency: done SHALL be high exactly 2+6*(SUM_W+1) cycles after the edge sampling start (80 for SUM_W=12).
REQ-022 Quotient = floor(sum/cnt); a quotient above 255 SHALL saturate to 255.
REQ-023 cnt=0: the divider still runs its full cycles (fixed latency), and both coordinates of that cluster SHALL keep the latched cen_in value; the empty_mask bit is set.
REQ-024 cen_out*, converged and empty_mask SHALL hold their values between DONE pulses.
REQ-025 start held high continuously SHALL begin a new update on the cycle after DONE (IDLE samples it).

Reset
REQ-026 reset=1 SHALL force IDLE; cen_out0..2=0, busy=0, done=0, converged=0, empty_mask=0, and clear divider state.
REQ-027 reset during LOAD/DIV/STORE/DONE SHALL abort the update with no done pulse and no partial cen_out change; reset overrides a simultaneous start.

Configuration
REQ-028 Macro KMEAN_ROUND_EN SHALL select the division rounding mode.
REQ-029 With KMEAN_ROUND_EN defined: quotient = floor((sum + floor(cnt/2))/cnt), with the dividend computed at SUM_W+1 bits, then saturated; latency is unchanged.
REQ-030 Without KMEAN_ROUND_EN: truncating division per REQ-022.

Verification
REQ-031 cen_in0=0x0001, sum_x0=30, sum_y0=12, cnt0=3 -> cen_out0=0x0A04 and done at cycle 80; busy high cycles 1-80.
REQ-032 sum_x1=7, sum_y1=7, cnt1=2 -> cen_out1=0x0303 without KMEAN_ROUND_EN and 0x0404 with it.
REQ-033 cnt1=0, cen_in1=0x0802 -> cen_out1=0x0802, empty_mask=3'b010; sum_x2=600, cnt2=2 -> x of cen_out2=0xFF.
REQ-034 Sums and counts chosen so every quotient equals cen_in (e.g. cen_in0=0x0A04 with sums 30/12, cnt 3) -> converged=1; change one sum by cnt -> converged=0.
REQ-035 Assert reset at cycle 40 of an update -> busy=0 next cycle, all outputs 0, no done pulse; a later start completes normally in 80 cycles.
REQ-036 Pulse start again at cycle 10 and change inputs mid-update -> ignored; results reflect the inputs latched in LOAD; exactly one done.
